pipe_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core: drives stall/flush of PC, IF/ID, ID/EX and EX/MEM.

---
 rtl/pipe_hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipe:
// load-use, multi-cycle divide, branch flush and memory wait.
module pipe_hazard_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1_raddr_i,
  input  logic        id_rs1_re_i,
  input  logic [4:0]  id_rs2_raddr_i,
  input  logic        id_rs2_re_i,
  input  logic [4:0]  ex_reg_waddr_i,
  input  logic        ex_mem_re_i,
  input  logic        ex_div_start_i,
  input  logic        ex_branch_taken_i,
  input  logic        mem_wait_i,
  output logic        pc_stall_o,
  output logic        if_id_stall_o,
  output logic        if_id_flush_o,
  output logic        id_ex_stall_o,
  output logic        id_ex_flush_o,
  output logic        ex_mem_stall_o,
  output logic        div_busy_o,
  output logic        div_done_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DIV  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(DIV_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic [31:0]      stall_cnt;

  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic cnt_zero;
  logic in_div;
  logic in_idle;

  // mutually exclusive selects, highest priority first
  logic sel_mw;
  logic sel_div_run;
  logic sel_div_done;
  logic sel_start;
  logic sel_branch;
  logic sel_lu;

  assign rs1_hit = id_rs1_re_i &
                   (id_rs1_raddr_i == ex_reg_waddr_i);
  assign rs2_hit = id_rs2_re_i &
                   (id_rs2_raddr_i == ex_reg_waddr_i);
  assign load_use = ex_mem_re_i &
                    (ex_reg_waddr_i != 5'd0) &
                    (rs1_hit | rs2_hit);

  assign cnt_zero = (cnt == '0);
  assign in_div   = (state == DIV);
  assign in_idle  = (state == IDLE);

  assign sel_mw = rst_n & mem_wait_i;

  assign sel_div_run = rst_n & ~mem_wait_i &
                       in_div & ~cnt_zero;

  assign sel_div_done = rst_n & ~mem_wait_i &
                        in_div & cnt_zero;

  assign sel_start = rst_n & ~mem_wait_i &
                     in_idle & ex_div_start_i;

  assign sel_branch = rst_n & ~mem_wait_i &
                      in_idle & ~ex_div_start_i &
                      ex_branch_taken_i;

  assign sel_lu = rst_n & ~mem_wait_i &
                  in_idle & ~ex_div_start_i &
                  ~ex_branch_taken_i & load_use;

  always_comb begin
    pc_stall_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_stall_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_stall_o = 1'b0;
    div_done_o     = 1'b0;
    unique case (1'b1)
      sel_mw, sel_div_run, sel_start: begin
        pc_stall_o     = 1'b1;
        if_id_stall_o  = 1'b1;
        id_ex_stall_o  = 1'b1;
        ex_mem_stall_o = 1'b1;
      end
      sel_div_done: begin
        div_done_o = 1'b1;
      end
      sel_branch: begin
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end
      sel_lu: begin
        pc_stall_o    = 1'b1;
        if_id_stall_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // counter keeps running under mem_wait; only the exit waits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ex_div_start_i && !mem_wait_i) begin
            state  <= DIV;
            cnt    <= CNT_INIT;
            busy_q <= 1'b1;
          end
        end
        DIV: begin
          if (!cnt_zero) begin
            cnt <= cnt - CNT_ONE;
          end else if (!mem_wait_i) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign div_busy_o = busy_q & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (pc_stall_o && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: per-cycle model compare
// plus directed literal checks.
module tb_pipe_hazard_ctrl;

  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1, rs2, waddr;
  logic        rs1_re, rs2_re, mem_re;
  logic        start, br, mw;
  logic        pc_stall, if_id_stall, if_id_flush;
  logic        id_ex_stall, id_ex_flush, ex_mem_stall;
  logic        busy, done;
  logic [31:0] scnt;

  int checks   = 0;
  int failures = 0;

  pipe_hazard_ctrl #(.DIV_CYCLES(DC), .CNT_W(3)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_rs1_raddr_i    (rs1),
    .id_rs1_re_i       (rs1_re),
    .id_rs2_raddr_i    (rs2),
    .id_rs2_re_i       (rs2_re),
    .ex_reg_waddr_i    (waddr),
    .ex_mem_re_i       (mem_re),
    .ex_div_start_i    (start),
    .ex_branch_taken_i (br),
    .mem_wait_i        (mw),
    .pc_stall_o        (pc_stall),
    .if_id_stall_o     (if_id_stall),
    .if_id_flush_o     (if_id_flush),
    .id_ex_stall_o     (id_ex_stall),
    .id_ex_flush_o     (id_ex_flush),
    .ex_mem_stall_o    (ex_mem_stall),
    .div_busy_o        (busy),
    .div_done_o        (done),
    .stall_cnt_o       (scnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // model: divide tracked by age since its accept cycle
  bit          m_div;
  int          m_age;
  longint      m_cnt;
  logic [7:0]  e;
  logic [7:0]  a;
  bit          lu;

  // e = {pc, ifid_st, ifid_fl, idex_st, idex_fl, exmem, busy, done}
  always @(negedge clk) begin
    a = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
         id_ex_flush, ex_mem_stall, busy, done};
    if (!rst_n) begin
      m_div = 0;
      m_age = 0;
      m_cnt = 0;
      chk("model_rst_out", {24'd0, a}, 32'd0);
      chk("model_rst_cnt", scnt, 32'd0);
    end else begin
      lu = mem_re && waddr != 0 &&
           ((rs1_re && rs1 == waddr) ||
            (rs2_re && rs2 == waddr));
      e = 8'b0;
      if (mw)
        e = 8'b1101_0100;
      else if (m_div)
        e = (m_age < DC - 1) ? 8'b1101_0100 : 8'b0000_0001;
      else if (start)
        e = 8'b1101_0100;
      else if (br)
        e = 8'b0010_1000;
      else if (lu)
        e = 8'b1100_1000;
      e[1] = m_div;
      chk("model_out", {24'd0, a}, {24'd0, e});
      chk("model_cnt", scnt, 32'(m_cnt));
      if (m_div) begin
        if (m_age >= DC - 1 && !mw) m_div = 0;
        else m_age++;
      end else if (start && !mw) begin
        m_div = 1;
        m_age = 1;
      end
      if (e[7] && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs1 = 0; rs2 = 0; waddr = 0;
    rs1_re = 0; rs2_re = 0; mem_re = 0;
    start = 0; br = 0; mw = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    tick(); tick();
    #2;
    chk("rst_pc", pc_stall, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", scnt, 32'd0);
    rst_n = 1'b1;

    // load-use on rs1
    tick();
    mem_re = 1; waddr = 5; rs1 = 5; rs1_re = 1;
    #2;
    chk("lu_pc", pc_stall, 1'b1);
    chk("lu_ifid", if_id_stall, 1'b1);
    chk("lu_flush", id_ex_flush, 1'b1);
    chk("lu_exmem", ex_mem_stall, 1'b0);
    tick();
    clr(); rs1 = 5; rs1_re = 1;
    #2;
    chk("lu_next_pc", pc_stall, 1'b0);
    chk("lu_next_fl", id_ex_flush, 1'b0);
    chk("lu_cnt", scnt, 32'd1);

    // no hazard: x0 dest, then rs1 not read
    tick();
    mem_re = 1; waddr = 0; rs1 = 0; rs1_re = 1;
    #2;
    chk("x0_pc", pc_stall, 1'b0);
    tick();
    waddr = 5; rs1 = 5; rs1_re = 0;
    #2;
    chk("nore_pc", pc_stall, 1'b0);
    chk("nore_fl", id_ex_flush, 1'b0);
    tick();
    rs2 = 5; rs2_re = 1;
    #2;
    chk("lu2_pc", pc_stall, 1'b1);
    tick();
    clr();

    // divide, DC=4, no wait
    tick();
    start = 1;
    #2;
    chk("div_t0_st", ex_mem_stall, 1'b1);
    tick(); tick();
    #2;
    chk("div_t2_st", pc_stall, 1'b1);
    chk("div_t2_busy", busy, 1'b1);
    tick();
    #2;
    chk("div_t3_done", done, 1'b1);
    chk("div_t3_st", pc_stall, 1'b0);
    tick();
    start = 0;
    #2;
    chk("div_t4_busy", busy, 1'b0);
    chk("div_t4_done", done, 1'b0);
    chk("div_cnt", scnt, 32'd5);

    // divide with mem_wait at t+3..t+4
    tick();
    start = 1;
    tick(); tick();
    tick();
    mw = 1;
    #2;
    chk("dmw_t3_done", done, 1'b0);
    chk("dmw_t3_st", id_ex_stall, 1'b1);
    tick();
    #2;
    chk("dmw_t4_done", done, 1'b0);
    tick();
    mw = 0;
    #2;
    chk("dmw_t5_done", done, 1'b1);
    tick();
    start = 0;
    #2;
    chk("dmw_cnt", scnt, 32'd10);

    // branch with load-use in same cycle
    tick();
    br = 1; mem_re = 1; waddr = 7; rs2 = 7; rs2_re = 1;
    #2;
    chk("br_ifid_fl", if_id_flush, 1'b1);
    chk("br_idex_fl", id_ex_flush, 1'b1);
    chk("br_pc", pc_stall, 1'b0);
    tick();
    clr();
    #2;
    chk("br_cnt", scnt, 32'd10);

    // mem_wait in IDLE, then start+branch (divide wins)
    tick();
    mw = 1; br = 1;
    #2;
    chk("mw_fl", if_id_flush, 1'b0);
    chk("mw_st", ex_mem_stall, 1'b1);
    tick();
    mw = 0; start = 1;
    #2;
    chk("sb_fl", if_id_flush, 1'b0);
    chk("sb_st", pc_stall, 1'b1);

    // reset at t+1 of the divide
    tick();
    rst_n = 0;
    #1;
    chk("rstdiv_pc", pc_stall, 1'b0);
    chk("rstdiv_busy", busy, 1'b0);
    chk("rstdiv_done", done, 1'b0);
    tick();
    clr();
    rst_n = 1;
    #2;
    chk("rel_cnt", scnt, 32'd0);
    chk("rel_busy", busy, 1'b0);
    repeat (5) begin
      tick();
      #2;
      chk("rel_done", done, 1'b0);
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
